// File: rtl/db_b3check_mch.sv
// Multi-channel, time-slot-interleaved B3/V5 BIP and PRBS-15 checker with per-channel
// HUNT/SYNC state and clear-on-read saturating error counters. Option: DB_B3CHK_BITERR_EN.
module db_b3check_mch #(
    parameter int NCH    = 4,
    parameter int CHW    = 2,
    parameter int CNTW   = 16,
    parameter int PKMOD  = 0,
    parameter int SYNCNT = 8,
    parameter int LOSCNT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  cfgcep,
    input  logic [NCH-1:0]  cfgvc3,
    input  logic [12:0]     cfgb3,
    input  logic            ivld,
    input  logic [CHW-1:0]  ichid,
    input  logic [7:0]      idat,
    input  logic            ij1,
    output logic            oerr,
    output logic [CHW-1:0]  oerrch,
    output logic [NCH-1:0]  osyn,
    input  logic            irden,
    input  logic [CHW-1:0]  irdch,
    output logic            ordvld,
    output logic [CNTW-1:0] ordcnt
);

    typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} sync_t;

    localparam int RUNMAX = (SYNCNT > LOSCNT) ? SYNCNT : LOSCNT;
    localparam int RUNW   = $clog2(RUNMAX + 1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

`ifdef DB_B3CHK_BITERR_EN
    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction
`endif

    // Frame length derived from the B3/V5 position of the supported container sizes.
    logic [15:0] b3max;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b3max <= 16'd37584;
        end else begin
            case (cfgb3)
                13'd86:   b3max <= 16'd765;
                13'd88:   b3max <= 16'd783;
                13'd262:  b3max <= 16'd2349;
                13'd1045: b3max <= 16'd9396;
                default:  b3max <= 16'd37584;
            endcase
        end
    end

    // Per-channel context
    logic [15:0]     fcnt_q  [NCH];
    logic [7:0]      sum_q   [NCH];
    logic [7:0]      lbip_q  [NCH];
    logic [14:0]     prbs_q  [NCH];
    sync_t           fsm_q   [NCH];
    logic [RUNW-1:0] good_q  [NCH];
    logic [RUNW-1:0] bad_q   [NCH];
    logic [CNTW-1:0] ecnt_q  [NCH];
    logic [NCH-1:0]  j1seen_q;

    logic            upd, rd_ok;
    logic [CHW-1:0]  ch, rch;

    logic [15:0]     c_cnt;
    logic [7:0]      c_sum, c_lbip;
    logic [14:0]     c_prbs;
    sync_t           c_fsm;
    logic [RUNW-1:0] c_good, c_bad;
    logic [CNTW-1:0] c_ecnt;
    logic            c_j1s;

    always_comb begin
        upd    = ivld && (32'(ichid) < NCH);
        ch     = upd ? ichid : '0;
        rd_ok  = irden && (32'(irdch) < NCH);
        rch    = rd_ok ? irdch : '0;
        c_cnt  = fcnt_q[ch];
        c_sum  = sum_q[ch];
        c_lbip = lbip_q[ch];
        c_prbs = prbs_q[ch];
        c_fsm  = fsm_q[ch];
        c_good = good_q[ch];
        c_bad  = bad_q[ch];
        c_ecnt = ecnt_q[ch];
        c_j1s  = j1seen_q[ch];
    end

    logic            j1pos, wrap, j1s_nxt, bip_err, prbs_err, err;
    logic [15:0]     cnt_nxt;
    logic [7:0]      sum_nxt, lbip_nxt, b3_mis, prbs_exp;
    logic [1:0]      fold, v5_mis;
    logic [14:0]     prbs_nxt, s;

    always_comb begin
        // NOTE: combinational logic uses blocking '=' so each line sees the results above it;
        // only clocked state uses non-blocking '<='.
        j1pos    = ij1 || (PKMOD == 1 && c_cnt == 16'd1);
        wrap     = !ij1 && (c_cnt >= b3max);
        cnt_nxt  = ij1 ? 16'd2 : (wrap ? 16'd1 : c_cnt + 16'd1);
        j1s_nxt  = ij1 ? 1'b1 : (wrap ? 1'b0 : c_j1s);
        lbip_nxt = j1pos ? c_sum : c_lbip;
        fold     = idat[7:6] ^ idat[5:4] ^ idat[3:2] ^ idat[1:0];
        b3_mis   = idat ^ c_lbip;
        v5_mis   = c_sum[1:0] ^ idat[7:6];
        if (cfgvc3[ch]) begin
            sum_nxt = j1pos ? idat : (c_sum ^ idat);
            bip_err = (c_cnt == {3'b000, cfgb3}) && (b3_mis != 8'h00);
        end else begin
            sum_nxt = {c_sum[7:2], (j1pos ? 2'b00 : c_sum[1:0]) ^ fold};
            bip_err = j1pos && (v5_mis != 2'b00);
        end

        // Bits arrive MSB first; each predicted bit is the XOR of the bits 15 and 14 back.
        prbs_exp = '0;
        s        = c_prbs;
        for (int i = 7; i >= 0; i--) begin
            prbs_exp[i] = s[14] ^ s[13];
            s           = {s[13:0], idat[i]};
        end
        prbs_err = (idat != prbs_exp);
        prbs_nxt = {c_prbs[6:0], idat};
    end

    sync_t           fsm_nxt;
    logic [RUNW-1:0] good_nxt, bad_nxt;

    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one unassigned (no latch).
        fsm_nxt  = c_fsm;
        good_nxt = c_good;
        bad_nxt  = c_bad;
        case (c_fsm)
            HUNT: begin
                if (prbs_err) begin
                    good_nxt = '0;
                end else if (c_good == RUNW'(SYNCNT - 1)) begin
                    fsm_nxt  = SYNC;
                    good_nxt = '0;
                    bad_nxt  = '0;
                end else begin
                    good_nxt = c_good + RUNW'(1);
                end
            end
            SYNC: begin
                if (!prbs_err) begin
                    bad_nxt = '0;
                end else if (c_bad == RUNW'(LOSCNT - 1)) begin
                    fsm_nxt  = HUNT;
                    good_nxt = '0;
                    bad_nxt  = '0;
                end else begin
                    bad_nxt = c_bad + RUNW'(1);
                end
            end
            default: fsm_nxt = HUNT;
        endcase
    end

    logic [3:0]      inc;
    logic [CNTW-1:0] ecnt_base, ecnt_nxt;
    logic [CNTW+3:0] ecnt_add;

    always_comb begin
        err = cfgcep[ch] ? bip_err : (prbs_err && c_fsm == SYNC);
`ifdef DB_B3CHK_BITERR_EN
        inc = cfgcep[ch] ? popcnt8(cfgvc3[ch] ? b3_mis : {6'b000000, v5_mis}) : 4'd1;
`else
        inc = 4'd1;
`endif
        // A read of the same channel clears first, so the increment lands on zero.
        ecnt_base = (rd_ok && rch == ch) ? '0 : c_ecnt;
        ecnt_add  = (CNTW+4)'(ecnt_base) + (CNTW+4)'(inc);
        ecnt_nxt  = (ecnt_add > (CNTW+4)'(CNT_MAX)) ? CNT_MAX : ecnt_add[CNTW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the context arrays are small flop banks, not RAM, so they reset like any flop.
            for (int i = 0; i < NCH; i++) begin
                fcnt_q[i] <= '0;
                sum_q[i]  <= '0;
                lbip_q[i] <= '0;
                prbs_q[i] <= 15'h7FFF;
                fsm_q[i]  <= HUNT;
                good_q[i] <= '0;
                bad_q[i]  <= '0;
            end
            j1seen_q <= '0;
        end else if (upd) begin
            fcnt_q[ch]   <= cnt_nxt;
            sum_q[ch]    <= sum_nxt;
            lbip_q[ch]   <= lbip_nxt;
            prbs_q[ch]   <= prbs_nxt;
            fsm_q[ch]    <= fsm_nxt;
            good_q[ch]   <= good_nxt;
            bad_q[ch]    <= bad_nxt;
            j1seen_q[ch] <= j1s_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) ecnt_q[i] <= '0;
        end else begin
            if (rd_ok) ecnt_q[rch] <= '0;
            if (upd && err) ecnt_q[ch] <= ecnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oerr   <= 1'b0;
            oerrch <= '0;
            ordvld <= 1'b0;
            ordcnt <= '0;
        end else begin
            oerr   <= upd && err;
            if (upd && err) oerrch <= ch;
            ordvld <= irden;
            if (irden) ordcnt <= rd_ok ? ecnt_q[rch] : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            osyn[i] = cfgcep[i] ? j1seen_q[i] : (fsm_q[i] == SYNC);
        end
    end

endmodule

// File: tb/tb_db_b3check_mch.sv
// Directed bench for db_b3check_mch: interleaved B3/V5/PRBS channels, reads, saturation
// (second instance with 4-bit counters), frame wrap and asynchronous reset.
module tb_db_b3check_mch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cfgcep = 4'b0111;
    logic [3:0]  cfgvc3 = 4'b0011;
    logic [12:0] cfgb3 = 13'd88;
    logic        ivld = 1'b0;
    logic [1:0]  ichid = '0;
    logic [7:0]  idat = '0;
    logic        ij1 = 1'b0;
    logic        irden = 1'b0;
    logic [1:0]  irdch = '0;

    logic        oerr, ordvld, s_oerr, s_ordvld;
    logic [1:0]  oerrch, s_oerrch;
    logic [3:0]  osyn, s_osyn;
    logic [15:0] ordcnt;
    logic [3:0]  s_ordcnt;

    always #5 clk = ~clk;

    db_b3check_mch u_dut (
        .clk(clk), .rst(rst), .cfgcep(cfgcep), .cfgvc3(cfgvc3), .cfgb3(cfgb3),
        .ivld(ivld), .ichid(ichid), .idat(idat), .ij1(ij1),
        .oerr(oerr), .oerrch(oerrch), .osyn(osyn),
        .irden(irden), .irdch(irdch), .ordvld(ordvld), .ordcnt(ordcnt)
    );

    db_b3check_mch #(.CNTW(4)) u_sat (
        .clk(clk), .rst(rst), .cfgcep(cfgcep), .cfgvc3(cfgvc3), .cfgb3(cfgb3),
        .ivld(ivld), .ichid(ichid), .idat(idat), .ij1(ij1),
        .oerr(s_oerr), .oerrch(s_oerrch), .osyn(s_osyn),
        .irden(irden), .irdch(irdch), .ordvld(s_ordvld), .ordcnt(s_ordcnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int c, input logic [7:0] d, input logic j1);
        ivld  = 1'b1;
        ichid = 2'(c);
        idat  = d;
        ij1   = j1;
        tick();
        ivld  = 1'b0;
        ij1   = 1'b0;
    endtask

    task automatic rd(input string tag, input int c, input int exp_m, input int exp_s);
        irden = 1'b1;
        irdch = 2'(c);
        tick();
        irden = 1'b0;
        check({tag, "_vld"}, 32'(ordvld), 32'd1);
        check(tag, 32'(ordcnt), 32'(exp_m));
        check({tag, "_sat"}, 32'(s_ordcnt), 32'(exp_s));
    endtask

    function automatic logic [1:0] fold(input logic [7:0] b);
        return b[7:6] ^ b[5:4] ^ b[3:2] ^ b[1:0];
    endfunction

    // Next clean PRBS-15 byte (MSB first) following the 15 most recent line bits in st.
    function automatic logic [7:0] prbs_next(input logic [14:0] st);
        logic [14:0] x;
        logic [7:0]  b;
        x = st;
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            b[i] = x[14] ^ x[13];
            x    = {x[13:0], b[i]};
        end
        return b;
    endfunction

    logic [7:0]  sum_m [2];
    logic [7:0]  lat_m [2];
    logic [1:0]  v5s;
    logic [14:0] g;
    logic [7:0]  d;
    logic        j1, ee;

    initial begin
        sum_m[0] = '0; sum_m[1] = '0;
        lat_m[0] = '0; lat_m[1] = '0;
        v5s = '0;
        g   = 15'h7FFF;

        #1;
        check("rst_oerr",   32'(oerr),   32'd0);
        check("rst_oerrch", 32'(oerrch), 32'd0);
        check("rst_osyn",   32'(osyn),   32'd0);
        check("rst_ordvld", 32'(ordvld), 32'd0);
        check("rst_ordcnt", 32'(ordcnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Round-robin: ch0/ch1 B3 (cfgb3=88), ch2 V5, ch3 PRBS; 120-byte frames.
        for (int k = 0; k <= 360; k++) begin
            for (int c = 0; c < 4; c++) begin
                d  = 8'($urandom);
                j1 = 1'b0;
                ee = 1'b0;
                if (c < 2) begin
                    if (k % 120 == 0) begin
                        j1 = 1'b1;
                        lat_m[c] = sum_m[c];
                        sum_m[c] = d;
                    end else begin
                        if (k % 120 == 87) begin
                            d = lat_m[c];
                            if (c == 1 && k == 207) begin
                                d[0] = ~d[0];
                                ee   = 1'b1;
                            end
                        end
                        sum_m[c] = sum_m[c] ^ d;
                    end
                end else if (c == 2) begin
                    if (k % 120 == 0) begin
                        j1     = 1'b1;
                        d[7:6] = v5s;
                        if (k == 240) begin
                            d[6] = ~d[6];
                            ee   = 1'b1;
                        end
                        v5s = fold(d);
                    end else begin
                        v5s = v5s ^ fold(d);
                    end
                end else begin
                    d = prbs_next(g);
                    if (k == 20 || k == 21 || (k >= 30 && k <= 32)) begin
                        d[4] = ~d[4];
                        ee   = 1'b1;
                    end
                    g = {g[6:0], d};
                end
                put(c, d, j1);
                check($sformatf("oerr_k%0d_c%0d", k, c), 32'(oerr), 32'(ee));
                if (ee) check($sformatf("oerrch_k%0d", k), 32'(oerrch), 32'(c));
                if (c == 3 && k <= 45)
                    check($sformatf("osyn3_k%0d", k), 32'(osyn[3]),
                          32'((k >= 7 && k <= 31) || k >= 40));
            end
        end
        check("osyn_end",     32'(osyn),   32'hF);
        check("osyn_end_sat", 32'(s_osyn), 32'hF);

        rd("rd_ch0", 0, 0, 0);
        rd("rd_ch1", 1, 1, 1);
        rd("rerd_ch1", 1, 0, 0);
        rd("rd_ch2", 2, 1, 1);
        rd("rd_ch3", 3, 5, 5);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        check("arst_oerr",     32'(oerr),     32'd0);
        check("arst_oerrch",   32'(oerrch),   32'd0);
        check("arst_osyn",     32'(osyn),     32'd0);
        check("arst_ordvld",   32'(ordvld),   32'd0);
        check("arst_ordcnt",   32'(ordcnt),   32'd0);
        check("arst_sat_osyn", 32'(s_osyn),   32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Saturation: every V5 byte after the first mismatches by one bit.
        for (int i = 0; i < 21; i++) begin
            put(2, 8'h01, 1'b1);
            check($sformatf("sat_oerr_%0d", i), 32'(oerr), 32'(i > 0));
        end
        tick();
        rd("rd_sat", 2, 20, 15);
        rd("rerd_sat", 2, 0, 0);
        put(2, 8'h01, 1'b1);
        check("pre_coll_oerr", 32'(oerr), 32'd1);
        ivld  = 1'b1; ichid = 2'd2; idat = 8'h01; ij1 = 1'b1;
        irden = 1'b1; irdch = 2'd2;
        tick();
        ivld  = 1'b0; ij1 = 1'b0; irden = 1'b0;
        check("coll_oerr",   32'(oerr),     32'd1);
        check("coll_rd",     32'(ordcnt),   32'd1);
        check("coll_rd_sat", 32'(s_ordcnt), 32'd1);
        rd("post_coll", 2, 1, 1);

        // Frame wrap at b3max=765 (cfgb3=86) clears J1-seen on ch0.
        cfgb3 = 13'd86;
        tick();
        put(0, 8'h00, 1'b1);
        for (int k = 1; k <= 764; k++) begin
            put(0, 8'h00, 1'b0);
            if (k == 85)  check("wrap_b3_oerr", 32'(oerr), 32'd0);
            if (k == 763) check("wrap_pre_osyn0", 32'(osyn[0]), 32'd1);
            if (k == 764) check("wrap_osyn0", 32'(osyn[0]), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
